dynamic_branch_predictor: RTL
=============================

Name: dynamic_branch_predictor

Overview:
- Parametrised successor to the ID-stage static BTFN predictor.
- B-type direction comes from a table of 2-bit saturating counters, indexed by PC, optionally XORed with a global history register (gshare).
- JAL and JALR handling is unchanged from the static scheme.
- The table is trained by a resolution port driven from EX. The lookup index is exported so it can be piped to EX and returned on update.

Parameters:
- IDX_BITS, 6: table index width; table depth = 2^IDX_BITS counters.
- GHR_BITS, 0: global history length; 0 = pure bimodal; legal 0..IDX_BITS.
- CNT_INIT, 2'b01: counter value loaded at reset (weakly not-taken).

Ports:
- clk, input, 1: clock; all state updates on rising edge.
- rstn, input, 1: reset, synchronous, active-low.
- branchBType, input, 1: ID instruction is beq/bne/blt/bge/bltu/bgeu.
- branchJAL, input, 1: ID instruction is jal.
- branchJALR, input, 1: ID instruction is jalr.
- rs1, input, 32: register data for jalr.
- offset, input, 32: sign-extended immediate.
- pc, input, 32: PC of the ID instruction.
- rs1_depended, input, 1: rs1 has an unresolved hazard (from hazard unit).
- redirection_pc, output, 32: predicted target to IF.
- taken, output, 1: redirect IF.
- pred_index, output, IDX_BITS: table index used for this lookup; pipe it to EX.
- update_valid, input, 1: EX resolved a B-type branch this cycle.
- update_index, input, IDX_BITS: pred_index carried with that branch.
- update_taken, input, 1: actual outcome.

Behaviour:
- Lookup is combinational, with zero-cycle latency to taken/redirection_pc.
  - Index = pc[IDX_BITS+1:2] XOR zero-extended ghr (ghr absent when GHR_BITS=0).
  - pred_index always equals this index, regardless of instruction type.
- Output priority, last assignment wins: default, then JAL, then JALR, then B-type.
  - Default: taken=0, redirection_pc=0.
  - JAL: taken=1, redirection_pc=pc+offset.
  - JALR with rs1_depended=1: taken=0.
  - JALR with rs1_depended=0: taken=1, redirection_pc=(rs1+offset)&32'hFFFFFFFE.
  - B-type: taken = counter[index][1]; redirection_pc = pc+offset in both directions.
- Address adds are modulo 2^32; wrap-around is not flagged.
- Counter update, on a clock edge with update_valid=1:
  - update_taken=1: counter[update_index] increments, saturating at 2'b11.
  - update_taken=0: counter[update_index] decrements, saturating at 2'b00.
  - Only the addressed entry changes.
- GHR update (GHR_BITS>0), on the same edge: ghr <= {ghr[GHR_BITS-2:0], update_taken}. For GHR_BITS=1, ghr <= update_taken.
  - History is speculation-free: it is updated only on resolution, never on prediction.
- Simultaneous lookup and update to the same index: the lookup sees the pre-edge value; there is no bypass.
  - The same rule applies to ghr, which is read pre-edge.
- Reset (rstn=0 at a clock edge):
  - Every counter loads CNT_INIT; ghr loads 0.
  - An update_valid in the same cycle is ignored.
  - Reset takes effect on the next edge regardless of pipeline state; pending EX updates are lost.
- Outputs have no registers and hence no reset value of their own. After reset, B-type lookups return taken = CNT_INIT[1] (0 at default).
- Multiple branch* inputs asserted together is illegal per the decoder; the priority above is still deterministic.

Optional Feature:
- Macro: DYNAMIC_BRANCH_PREDICTOR_STATS_EN.
- When defined:
  - Adds outputs stat_updates[31:0] and stat_mispredicts[31:0], plus input update_pred[1] (the prediction made for the resolved branch).
  - On each update_valid edge, stat_updates increments. stat_mispredicts increments when update_pred != update_taken.
  - Both counters wrap modulo 2^32 and clear to 0 on reset.
- When undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset, then branchBType=1, pc=0x100, offset=0xFFFFFFF0 → taken=0, redirection_pc=0xF0. Same stimulus with offset=0x20 → taken=0, redirection_pc=0x120.
- Two update_valid edges with update_index=pred_index(pc=0x100), update_taken=1 → counter 01→10→11; lookup at pc=0x100 gives taken=1. Three not-taken updates → 11→10→01→00; a fourth stays at 00 and taken=0.
- Train pc=0x100 to taken; lookup pc=0x100+(4<<IDX_BITS) (aliasing) → taken=1. Lookup pc=0x104 → unaffected, taken=0.
- branchJALR=1, rs1=0x1001, offset=4, rs1_depended=0 → taken=1, redirection_pc=0x1004. With rs1_depended=1 → taken=0. branchJAL=1, pc=0x200, offset=0x40 → taken=1, redirection_pc=0x240.
- GHR_BITS=2: updates taken,taken → ghr=2'b11. Lookup pc=0x0 then uses index 3; pred_index=3.
- Update and lookup to the same index in one cycle with counter=01, update_taken=1 → that cycle's taken=0, next cycle taken=1. Assert rstn=0 during an update → counter remains CNT_INIT. With STATS_EN: 3 updates, one of them mismatched → stat_updates=3, stat_mispredicts=1.

Source files
------------

// File: rtl/dynamic_branch_predictor_if.sv
// ID/EX-side bundle for dynamic_branch_predictor: lookup request, prediction, resolution.
// Latency: n/a (wires only); prediction fields are combinational from the lookup fields.
// Backpressure: none; lookups and updates are accepted every cycle.
// Optional stats fields exist only when DYNAMIC_BRANCH_PREDICTOR_STATS_EN is defined.
interface dynamic_branch_predictor_if #(
  parameter int IDX_BITS = 6
);
  // lookup request from ID
  logic                branchBType;
  logic                branchJAL;
  logic                branchJALR;
  logic [31:0]         rs1;
  logic [31:0]         offset;
  logic [31:0]         pc;
  logic                rs1_depended;
  // prediction back to IF / pipe to EX
  logic [31:0]         redirection_pc;
  logic                taken;
  logic [IDX_BITS-1:0] pred_index;
  // resolution from EX
  logic                update_valid;
  logic [IDX_BITS-1:0] update_index;
  logic                update_taken;
`ifdef DYNAMIC_BRANCH_PREDICTOR_STATS_EN
  logic                update_pred;
  logic [31:0]         stat_updates;
  logic [31:0]         stat_mispredicts;
`endif

`ifdef DYNAMIC_BRANCH_PREDICTOR_STATS_EN
  // pipeline side
  modport master (
    output branchBType, branchJAL, branchJALR, rs1, offset, pc, rs1_depended,
    output update_valid, update_index, update_taken, update_pred,
    input  redirection_pc, taken, pred_index, stat_updates, stat_mispredicts
  );
  // predictor side
  modport slave (
    input  branchBType, branchJAL, branchJALR, rs1, offset, pc, rs1_depended,
    input  update_valid, update_index, update_taken, update_pred,
    output redirection_pc, taken, pred_index, stat_updates, stat_mispredicts
  );
`else
  // pipeline side
  modport master (
    output branchBType, branchJAL, branchJALR, rs1, offset, pc, rs1_depended,
    output update_valid, update_index, update_taken,
    input  redirection_pc, taken, pred_index
  );
  // predictor side
  modport slave (
    input  branchBType, branchJAL, branchJALR, rs1, offset, pc, rs1_depended,
    input  update_valid, update_index, update_taken,
    output redirection_pc, taken, pred_index
  );
`endif
endinterface

// File: rtl/dynamic_branch_predictor.sv
// Dynamic branch predictor: 2-bit saturating counter table (bimodal or gshare) for B-type, static JAL/JALR.
// Latency: zero-cycle combinational lookup; table/history written on the rising edge of a resolution.
// Backpressure: none; one lookup and one update accepted every cycle, no bypass from update to lookup.
// Optional statistics counters are enabled by defining DYNAMIC_BRANCH_PREDICTOR_STATS_EN.
module dynamic_branch_predictor #(
  parameter int         IDX_BITS = 6,
  parameter int         GHR_BITS = 0,      // 0 = pure bimodal, legal 0..IDX_BITS
  parameter logic [1:0] CNT_INIT = 2'b01   // weakly not-taken
) (
  input  logic                       clk,
  input  logic                       rstn,
  dynamic_branch_predictor_if.slave  bp
);

  localparam int DEPTH = 1 << IDX_BITS;

  logic [1:0]          r_cnt [DEPTH];
  logic [IDX_BITS-1:0] w_ghr_ext;
  logic [IDX_BITS-1:0] w_index;
  logic [1:0]          w_cnt_rd;
  logic [1:0]          w_upd_cur;
  logic [1:0]          w_upd_next;
  logic [31:0]         w_pc_tgt;
  logic [31:0]         w_jalr_tgt;
  logic                w_taken;
  logic [31:0]         w_redir;

  // Global history: only exists when GHR_BITS > 0; shifted on resolution, never on prediction.
  generate
    if (GHR_BITS > 0) begin : g_ghr
      logic [GHR_BITS-1:0] r_ghr;

      if (GHR_BITS == 1) begin : g_one
        // single-bit history simply holds the last resolved outcome
        always_ff @(posedge clk) begin
          if (!rstn)
            r_ghr <= '0;
          else if (bp.update_valid)
            r_ghr <= bp.update_taken;
        end
      end else begin : g_multi
        // shift the resolved outcome into the LSB
        always_ff @(posedge clk) begin
          if (!rstn)
            r_ghr <= '0;
          else if (bp.update_valid)
            r_ghr <= {r_ghr[GHR_BITS-2:0], bp.update_taken};
        end
      end

      assign w_ghr_ext = IDX_BITS'(r_ghr);
    end else begin : g_no_ghr
      assign w_ghr_ext = '0;
    end
  endgenerate

  // Lookup index; word-aligned PC bits folded with pre-edge history.
  assign w_index       = bp.pc[IDX_BITS+1:2] ^ w_ghr_ext;
  assign w_cnt_rd      = r_cnt[w_index];
  assign bp.pred_index = w_index;

  // Branch targets; both adds wrap modulo 2^32, jalr clears bit 0.
  assign w_pc_tgt   = bp.pc + bp.offset;
  assign w_jalr_tgt = (bp.rs1 + bp.offset) & 32'hFFFF_FFFE;

  // Redirect decision: later branches override earlier ones (JAL < JALR < B-type).
  always_comb begin
    w_taken = 1'b0;
    w_redir = 32'h0;
    if (bp.branchJAL) begin
      w_taken = 1'b1;
      w_redir = w_pc_tgt;
    end
    if (bp.branchJALR) begin
      if (bp.rs1_depended) begin
        // rs1 not yet available: let IF fall through, keep whatever target was selected
        w_taken = 1'b0;
      end else begin
        w_taken = 1'b1;
        w_redir = w_jalr_tgt;
      end
    end
    if (bp.branchBType) begin
      // target is presented in both directions so EX can redirect cheaply on mispredict
      w_taken = w_cnt_rd[1];
      w_redir = w_pc_tgt;
    end
  end

  assign bp.taken          = w_taken;
  assign bp.redirection_pc = w_redir;

  // Saturating next value for the entry being trained.
  assign w_upd_cur = r_cnt[bp.update_index];
  always_comb begin
    w_upd_next = w_upd_cur;
    if (bp.update_taken) begin
      if (w_upd_cur != 2'b11)
        w_upd_next = w_upd_cur + 2'b01;
    end else begin
      if (w_upd_cur != 2'b00)
        w_upd_next = w_upd_cur - 2'b01;
    end
  end

  // Counter table: reset wins over a coincident update; only the addressed entry is written.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++)
        r_cnt[i] <= CNT_INIT;
    end else if (bp.update_valid) begin
      r_cnt[bp.update_index] <= w_upd_next;
    end
  end

`ifdef DYNAMIC_BRANCH_PREDICTOR_STATS_EN
  logic [31:0] r_stat_updates;
  logic [31:0] r_stat_mispredicts;

  // Resolution and misprediction counters, free-running and wrapping.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_stat_updates     <= 32'h0;
      r_stat_mispredicts <= 32'h0;
    end else if (bp.update_valid) begin
      r_stat_updates <= r_stat_updates + 32'h1;
      if (bp.update_pred != bp.update_taken)
        r_stat_mispredicts <= r_stat_mispredicts + 32'h1;
    end
  end

  assign bp.stat_updates     = r_stat_updates;
  assign bp.stat_mispredicts = r_stat_mispredicts;
`endif

endmodule
